hiscore_ram_arbiter: RTL



---
 rtl/hiscore_ram_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM port arbiter between the Z80 and the hiscore save/restore engine.
// The engine gets the port only inside a safe window, after the CPU is paused and drained.
module hiscore_ram_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int RD_LAT   = 1,
    parameter int GUARD    = 2,
    parameter int MAX_HOLD = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vblank,
    input  logic          user_paused,
    input  logic          hs_intent_rd,
    input  logic          hs_intent_wr,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    input  logic          hs_re,
    output logic          hs_grant,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_rvalid,
    output logic          hs_overrun,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_pause,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {IDLE, WAIT_WIN, DRAIN, GRANT, RELEASE} state_t;

    localparam logic [3:0]  GUARD_C = 4'(GUARD);
    localparam logic [3:0]  LAT_C   = 4'(RD_LAT);
    localparam logic [15:0] HOLD_C  = 16'(MAX_HOLD);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   hold_q, hold_d;
    logic          overrun_q, overrun_d;
    logic          intent, window;

    assign intent = hs_intent_rd | hs_intent_wr;
    assign window = vblank | user_paused;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
        end
    end

    // cnt_q is shared: drain countdown in DRAIN, read-completion countdown in RELEASE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (intent) state_d = WAIT_WIN;
            end
            WAIT_WIN: begin
                if (!intent) begin
                    state_d = IDLE;
                end else if (window) begin
                    state_d = DRAIN;
                    cnt_d   = GUARD_C;
                end
            end
            DRAIN: begin
                if (!intent) begin
                    state_d = RELEASE;
                    cnt_d   = LAT_C;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = GRANT;
                        hold_d  = '0;
                    end
                end
            end
            GRANT: begin
                if (!intent) begin
                    state_d = RELEASE;
                    cnt_d   = LAT_C;
                end else if (!user_paused) begin
                    // The OSD pause freezes the hold budget, so no overrun while it is active.
                    hold_d = hold_q + 16'd1;
                    if (hold_d == HOLD_C) begin
                        state_d   = RELEASE;
                        cnt_d     = LAT_C;
                        overrun_d = 1'b1;
                    end
                end
            end
            RELEASE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs_grant   = (state_q == GRANT);
    assign cpu_pause  = (state_q == DRAIN) || (state_q == GRANT) || (state_q == RELEASE);
    assign hs_overrun = overrun_q;

    assign ram_addr  = hs_grant ? hs_addr  : cpu_addr;
    assign ram_wdata = hs_grant ? hs_wdata : cpu_wdata;
    assign ram_we    = hs_grant ? hs_we    : (cpu_we & ~cpu_pause);
    assign cpu_rdata = ram_rdata;

    // Read-tag pipeline keeps running after release so the final read still lands.
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [DW-1:0]     hs_rdata_q;
    logic              hs_rvalid_q;

    genvar gi;
    for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
        if (gi == 0) begin : g_head
            assign rd_pipe_d[gi] = hs_re & hs_grant;
        end else begin : g_tail
            assign rd_pipe_d[gi] = rd_pipe_q[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe_q   <= '0;
            hs_rvalid_q <= 1'b0;
            hs_rdata_q  <= '0;
        end else begin
            rd_pipe_q   <= rd_pipe_d;
            hs_rvalid_q <= rd_pipe_q[RD_LAT-1];
            if (rd_pipe_q[RD_LAT-1]) hs_rdata_q <= ram_rdata;
        end
    end

    assign hs_rdata  = hs_rdata_q;
    assign hs_rvalid = hs_rvalid_q;

endmodule
